// File: rtl/uart_response_framer.sv
// Frames a command/response as "[CMD:XX] [LEN:YYYY] [<payload>] [CKSUM:ZZ]\n"
// and streams it one byte per handshake into the UART TX byte port.
module uart_response_framer #(
    parameter int unsigned MAX_LEN = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        len_err
);

    typedef enum logic [2:0] {IDLE, HDR, PAY_OPEN, PAYLOAD, PAY_CLOSE, CKS} state_t;

    localparam logic [15:0] MAX_LEN_L = MAX_LEN[15:0];

    state_t      state_reg, state_next;
    logic [4:0]  idx_reg, idx_next;
    logic [15:0] pay_cnt_reg, pay_cnt_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic [15:0] len_reg, len_next;
    logic [7:0]  cksum_reg, cksum_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        frame_done_reg, frame_done_next;
    logic        len_err_reg, len_err_next;
    logic        tx_load;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hdr_char(input logic [4:0] i, input logic [7:0] c,
                                            input logic [15:0] l);
        case (i)
            5'd0:    return 8'h5B;  // [
            5'd1:    return 8'h43;  // C
            5'd2:    return 8'h4D;  // M
            5'd3:    return 8'h44;  // D
            5'd4:    return 8'h3A;  // :
            5'd5:    return hex(c[7:4]);
            5'd6:    return hex(c[3:0]);
            5'd7:    return 8'h5D;  // ]
            5'd8:    return 8'h20;
            5'd9:    return 8'h5B;
            5'd10:   return 8'h4C;  // L
            5'd11:   return 8'h45;  // E
            5'd12:   return 8'h4E;  // N
            5'd13:   return 8'h3A;
            5'd14:   return hex(l[15:12]);
            5'd15:   return hex(l[11:8]);
            5'd16:   return hex(l[7:4]);
            5'd17:   return hex(l[3:0]);
            5'd18:   return 8'h5D;
            default: return 8'h20;
        endcase
    endfunction

    function automatic logic [7:0] cks_char(input logic [4:0] i, input logic [7:0] s);
        case (i)
            5'd0:    return 8'h5B;  // [
            5'd1:    return 8'h43;  // C
            5'd2:    return 8'h4B;  // K
            5'd3:    return 8'h53;  // S
            5'd4:    return 8'h55;  // U
            5'd5:    return 8'h4D;  // M
            5'd6:    return 8'h3A;  // :
            5'd7:    return hex(s[7:4]);
            5'd8:    return hex(s[3:0]);
            5'd9:    return 8'h5D;  // ]
            default: return 8'h0A;
        endcase
    endfunction

    assign tx_load       = !tx_valid_reg || uart_tx_ready;
    assign req_ready     = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign pl_ready      = (state_reg == PAYLOAD) && tx_load;
    assign uart_tx_data  = tx_data_reg;
    assign uart_tx_valid = tx_valid_reg;
    assign frame_done    = frame_done_reg;
    assign len_err       = len_err_reg;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        pay_cnt_next    = pay_cnt_reg;
        cmd_next        = cmd_reg;
        len_next        = len_reg;
        cksum_next      = cksum_reg;
        tx_data_next    = tx_data_reg;
        tx_valid_next   = tx_valid_reg && !uart_tx_ready;
        frame_done_next = 1'b0;
        len_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                // The output register is always empty here, so '[' loads at once.
                if (req_valid) begin
                    if (req_len > MAX_LEN_L) begin
                        len_err_next = 1'b1;
                    end else begin
                        cmd_next      = req_cmd;
                        len_next      = req_len;
                        cksum_next    = req_cmd + req_len[7:0] + req_len[15:8];
                        tx_data_next  = 8'h5B;
                        tx_valid_next = 1'b1;
                        idx_next      = 5'd1;
                        state_next    = HDR;
                    end
                end
            end
            HDR: begin
                if (tx_load) begin
                    tx_data_next  = hdr_char(idx_reg, cmd_reg, len_reg);
                    tx_valid_next = 1'b1;
                    if (idx_reg == 5'd19) begin
                        idx_next   = 5'd0;
                        state_next = (len_reg != 16'd0) ? PAY_OPEN : CKS;
                    end else begin
                        idx_next = idx_reg + 5'd1;
                    end
                end
            end
            PAY_OPEN: begin
                if (tx_load) begin
                    tx_data_next  = 8'h5B;
                    tx_valid_next = 1'b1;
                    pay_cnt_next  = 16'd0;
                    state_next    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (tx_load && pl_valid) begin
                    tx_data_next  = pl_data;
                    tx_valid_next = 1'b1;
                    cksum_next    = cksum_reg + pl_data;
                    if (pay_cnt_reg == len_reg - 16'd1) begin
                        state_next = PAY_CLOSE;
                    end else begin
                        pay_cnt_next = pay_cnt_reg + 16'd1;
                    end
                end
            end
            PAY_CLOSE: begin
                if (tx_load) begin
                    tx_valid_next = 1'b1;
                    if (idx_reg == 5'd0) begin
                        tx_data_next = 8'h5D;
                        idx_next     = 5'd1;
                    end else begin
                        tx_data_next = 8'h20;
                        idx_next     = 5'd0;
                        state_next   = CKS;
                    end
                end
            end
            CKS: begin
                // Index 11 means '\n' is loaded; finish once the UART takes it.
                if (idx_reg == 5'd11) begin
                    if (tx_valid_reg && uart_tx_ready) begin
                        idx_next        = 5'd0;
                        frame_done_next = 1'b1;
                        state_next      = IDLE;
                    end
                end else if (tx_load) begin
                    tx_data_next  = cks_char(idx_reg, cksum_reg);
                    tx_valid_next = 1'b1;
                    idx_next      = idx_reg + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 5'd0;
            pay_cnt_reg    <= 16'd0;
            cmd_reg        <= 8'd0;
            len_reg        <= 16'd0;
            cksum_reg      <= 8'd0;
            tx_data_reg    <= 8'd0;
            tx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            pay_cnt_reg    <= pay_cnt_next;
            cmd_reg        <= cmd_next;
            len_reg        <= len_next;
            cksum_reg      <= cksum_next;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= tx_valid_next;
            frame_done_reg <= frame_done_next;
            len_err_reg    <= len_err_next;
        end
    end

endmodule

// File: doc/uart_response_framer.md
Name: uart_response_framer

Overview:
- Serializes outbound command/response frames from FPGA logic to the SAMD51 over UART0, one byte per handshake.
- Frame format, ASCII framing with raw binary payload: "[CMD:XX] [LEN:YYYY] [<payload>] [CKSUM:ZZ]\n".
- Sits between response/telemetry sources (ACK/NAK, captured reports) and the uart_interface TX byte port.
- Produces exactly the byte stream that the existing FPGA-side UART command parser accepts.

Parameters:
- MAX_LEN, 128, largest payload length accepted, in bytes (1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  frame request present
- req_ready  out  1  framer can accept a request
- req_cmd  in  8  command/response code
- req_len  in  16  payload length in bytes
- pl_data  in  8  payload byte
- pl_valid  in  1  payload byte present
- pl_ready  out  1  payload byte consumed this cycle when pl_valid=1
- uart_tx_data  out  8  byte to UART
- uart_tx_valid  out  1  uart_tx_data valid
- uart_tx_ready  in  1  UART accepts byte
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the final '\n' is accepted
- len_err  out  1  one-cycle pulse when a request is rejected (req_len > MAX_LEN)

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except req_ready=1; checksum, counters and latched cmd/len cleared.
  - Reset mid-frame abandons the partial frame, and uart_tx_valid drops immediately.
  - No resume; the receiver resynchronises on the next '['.
- Request handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready = (state==IDLE).
  - cmd and len are latched on acceptance.
- Rejected request: if req_len > MAX_LEN at acceptance, it is consumed, len_err pulses in the next cycle, no bytes are sent, and the state stays IDLE.
- Output register handshake:
  - A new byte loads into uart_tx_data/uart_tx_valid only when (!uart_tx_valid || uart_tx_ready).
  - While uart_tx_valid && !uart_tx_ready, uart_tx_data is held stable.
  - uart_tx_valid stays 1 continuously through a frame when ready=1, giving one byte per clk.
  - After the final byte is accepted, uart_tx_valid=0 unless the next frame's '[' loads in the same cycle.
- Latency:
  - Request accepted at cycle T gives '[' on uart_tx_data with valid=1 at T+1.
  - A back-to-back request may be accepted in the cycle after frame_done.
- Hex encoding: nibble n<10 -> 0x30+n, else 0x37+n (uppercase). Most-significant nibble first.
- States and transitions:
  - IDLE: the accept/reject rules above apply.
  - HDR: emits "[CMD:" + 2 hex(cmd) + "] [LEN:" + 4 hex(len) + "] ".
    - Index counter 0..19.
    - Then PAY_OPEN if len>0, else CKS.
  - PAY_OPEN: emits "[", then PAYLOAD.
  - PAYLOAD:
    - pl_ready = (state==PAYLOAD) && (!uart_tx_valid || uart_tx_ready).
    - A consumed pl_data goes out unmodified, including bytes 0x0A, '[' and ']'.
    - Payload counter increments per byte; after byte len-1 is consumed, go to PAY_CLOSE.
    - pl_valid=0 stalls the frame with no timeout, and uart_tx_valid drops once the held byte is taken.
  - PAY_CLOSE: emits "] ", then CKS.
  - CKS: emits "[CKSUM:" + 2 hex(cksum) + "]" + 0x0A, then IDLE.
    - frame_done pulses in the cycle after 0x0A is accepted.
- Checksum: 8-bit wrap-around sum of cmd + len[7:0] + len[15:8] + every payload byte. It is computed incrementally and final before CKS emits its hex digits.
- Frame length: 34+len bytes for len>0; 31 bytes for len=0.
- busy = (state != IDLE).
- pl_ready=0 in every state except PAYLOAD. Payload bytes presented outside PAYLOAD are not consumed.
- Request inputs are ignored while busy; only the latched values are used.

Test Plan:
- cmd=0x10, len=8, payload 01..08, tx_ready=1 -> 42 bytes "[CMD:10] [LEN:0008] [" 01..08 "] [CKSUM:3C]\n", contiguous valid, frame_done once, cycle after last byte.
- cmd=0x21, len=0 -> exactly "[CMD:21] [LEN:0000] [CKSUM:21]\n" (31 bytes); pl_ready never asserted.
- cmd=0xFF, len=2, payload FF FF -> checksum wraps to 0xFF, trailer "[CKSUM:FF]\n"; payload 0x0A/0x5B bytes pass through verbatim.
- Random uart_tx_ready and pl_valid gaps on a 16-byte frame -> no byte dropped/duplicated; data stable while valid&&!ready; byte sequence identical to the ready=1 run.
- req_len=0x0081 with MAX_LEN=128 -> len_err pulse, zero uart_tx_valid cycles; next valid request is framed normally.
- Assert rst_n low mid-PAYLOAD -> uart_tx_valid=0, busy=0, req_ready=1 immediately; the following request produces a complete, correct frame.
